onehot_sequencer: RTL and testbench
===================================

ONEHOT_SEQUENCER -- requirements
Module: onehot_sequencer

Interface
REQ-001 The block SHALL have parameter SEL_W, default 4, meaning the state-index width; the output is 2**SEL_W bits wide.
REQ-002 The block SHALL have parameter LAST, default 2**SEL_W-1, meaning the final state index before wrap; legal range 0..2**SEL_W-1.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port clr_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port en, input, 1 bit: advance enable.
REQ-006 The block SHALL have port restart, input, 1 bit: synchronous return to index 0.
REQ-007 The block SHALL have port load, input, 1 bit: synchronous jump to load_sel.
REQ-008 The block SHALL have port load_sel, input, SEL_W bits: jump target index.
REQ-009 The block SHALL have port hlt, input, 1 bit: halt request.
REQ-010 The block SHALL have port out, output, 2**SEL_W bits: one-hot decode of the current index; all zeros when not in RUN.
REQ-011 The block SHALL have port sel_q, output, SEL_W bits: the current index.
REQ-012 The block SHALL have port wrap, output, 1 bit: one-cycle pulse on LAST->0 advance.
REQ-013 The block SHALL have port halted, output, 1 bit: high while in HALT.

Function
REQ-014 The block SHALL implement states IDLE, RUN and HALT.
REQ-015 In IDLE, the block SHALL hold sel_q=0 and out=0; on en=1 it SHALL go to RUN with sel_q=0, and out SHALL show bit 0 from the next cycle.
REQ-016 In RUN, the block SHALL assert out[sel_q] exactly, with all other bits 0.
REQ-017 The block SHALL give per-cycle priority in RUN in this order: restart > load > hlt > en > hold.
REQ-018 In RUN with en=1, sel_q SHALL increment by 1; at sel_q==LAST it SHALL become 0 and wrap SHALL be 1 for that following cycle.
REQ-019 With en=0 and no other request in RUN, sel_q and out SHALL hold.
REQ-020 load in RUN or HALT SHALL set sel_q=load_sel and enter RUN; if load_sel>LAST, sel_q SHALL be 0 instead.
REQ-021 restart in any state SHALL set sel_q=0 and enter RUN.
REQ-022 hlt in RUN SHALL enter HALT with sel_q frozen, out=0 and halted=1.
REQ-023 In HALT, en and hlt SHALL be ignored; only restart, load or reset SHALL exit HALT.
REQ-024 In IDLE, load and restart SHALL also enter RUN per REQ-020 and REQ-021, and hlt SHALL be ignored.
REQ-025 The block SHALL raise wrap only on an en-driven LAST->0 step, never on restart or load.
REQ-026 With LAST=0, every en in RUN SHALL pulse wrap while sel_q stays 0.
REQ-027 The out latency SHALL be 0 cycles from sel_q, i.e. combinational decode of the registered state, unless the macro in REQ-031 is defined.

Reset
REQ-028 clr_n=0 SHALL immediately force IDLE, sel_q=0, out=0, wrap=0 and halted=0, independent of clk.
REQ-029 Reset mid-RUN or mid-HALT SHALL discard the state, and the first en after deassertion SHALL restart at index 0.
REQ-030 clr_n deassertion SHALL be synchronised externally; the block SHALL require no clk edge to reach its reset values.

Configuration
REQ-031 With ONEHOT_OUT_REG_EN defined, out and wrap SHALL be registered: one extra cycle of latency relative to sel_q and halted, reset to 0 by clr_n.
REQ-032 Without ONEHOT_OUT_REG_EN, out and wrap SHALL be combinational from the state registers, per REQ-027.

Verification
REQ-033 The bench SHALL cover, with SEL_W=4 and LAST=5: reset, then en=1 for 8 cycles -> out=0x0001,0x0002,..,0x0020,0x0001,0x0002; wrap high exactly once, with sel_q=0 after 0x0020.
REQ-034 The bench SHALL cover: in RUN at sel_q=3, assert hlt -> out=0x0000, halted=1, sel_q=3; then en for 4 cycles -> no change; then restart -> out=0x0001, halted=0.
REQ-035 The bench SHALL cover: in RUN at sel_q=2, assert load=1 with load_sel=9 (>LAST) -> sel_q=0; with load_sel=4 -> sel_q=4, out=0x0010, wrap=0.
REQ-036 The bench SHALL cover: restart, load and hlt asserted together at sel_q=4 -> sel_q=0 and RUN (restart wins).
REQ-037 The bench SHALL cover: clr_n pulsed low between clock edges during HALT -> outputs go to 0 before the next edge; the next en gives out=0x0001.
REQ-038 The bench SHALL cover: ONEHOT_OUT_REG_EN defined, repeat REQ-033 -> identical out sequence delayed by one cycle relative to sel_q.

Source files
------------

// File: rtl/onehot_sequencer_if.sv
// Control and status bundle for onehot_sequencer: the requests going in and the decoded index coming out.
interface onehot_sequencer_if #(
   parameter int SEL_W = 4
);
   logic                  en;
   logic                  restart;
   logic                  load;
   logic [SEL_W-1:0]      load_sel;
   logic                  hlt;
   logic [2**SEL_W-1:0]   out;
   logic [SEL_W-1:0]      sel_q;
   logic                  wrap;
   logic                  halted;

   modport master (
      output en, restart, load, load_sel, hlt,
      input  out, sel_q, wrap, halted
   );

   modport slave (
      input  en, restart, load, load_sel, hlt,
      output out, sel_q, wrap, halted
   );
endinterface

// File: rtl/onehot_sequencer.sv
// One-hot index sequencer with IDLE/RUN/HALT control, wrap pulse and clamped load.
// Define ONEHOT_OUT_REG_EN to register out and wrap (one extra cycle of latency).
module onehot_sequencer #(
   parameter int SEL_W = 4,
   parameter int LAST  = 2**SEL_W-1
) (
   input  logic                   clk,
   input  logic                   clr_n,
   onehot_sequencer_if.slave      bus
);
   localparam int OUT_W = 2**SEL_W;
   localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(LAST);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } state_t;

   state_t           state_reg, state_next;
   logic [SEL_W-1:0] sel_reg, sel_next;
   logic             wrap_reg, wrap_next;
   logic [SEL_W-1:0] load_target;
   logic [OUT_W-1:0] out_comb;

   // Out-of-range jump targets fall back to index 0
   assign load_target = (bus.load_sel > LAST_SEL) ? '0 : bus.load_sel;

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state_reg <= IDLE;
         sel_reg   <= '0;
         wrap_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         sel_reg   <= sel_next;
         wrap_reg  <= wrap_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      sel_next   = sel_reg;
      wrap_next  = 1'b0;
      case (state_reg)
         IDLE: begin
            if (bus.restart) begin
               state_next = RUN;
               sel_next   = '0;
            end else if (bus.load) begin
               state_next = RUN;
               sel_next   = load_target;
            end else if (bus.en) begin
               state_next = RUN;
               sel_next   = '0;
            end
         end
         RUN: begin
            if (bus.restart) begin
               sel_next = '0;
            end else if (bus.load) begin
               sel_next = load_target;
            end else if (bus.hlt) begin
               state_next = HALT;
            end else if (bus.en) begin
               if (sel_reg == LAST_SEL) begin
                  sel_next  = '0;
                  wrap_next = 1'b1;
               end else begin
                  sel_next = sel_reg + SEL_W'(1);
               end
            end
         end
         HALT: begin
            if (bus.restart) begin
               state_next = RUN;
               sel_next   = '0;
            end else if (bus.load) begin
               state_next = RUN;
               sel_next   = load_target;
            end
         end
         default: begin
            state_next = IDLE;
            sel_next   = '0;
         end
      endcase
   end

   genvar gi;
   generate
      for (gi = 0; gi < OUT_W; gi++) begin : g_decode
         assign out_comb[gi] = (state_reg == RUN) && (sel_reg == SEL_W'(gi));
      end
   endgenerate

   assign bus.sel_q  = sel_reg;
   assign bus.halted = (state_reg == HALT);

`ifdef ONEHOT_OUT_REG_EN
   logic [OUT_W-1:0] out_reg;
   logic             wrap_out_reg;

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         out_reg      <= '0;
         wrap_out_reg <= 1'b0;
      end else begin
         out_reg      <= out_comb;
         wrap_out_reg <= wrap_reg;
      end
   end

   assign bus.out  = out_reg;
   assign bus.wrap = wrap_out_reg;
`else
   assign bus.out  = out_comb;
   assign bus.wrap = wrap_reg;
`endif

endmodule

// File: tb/tb_onehot_sequencer.sv
// Directed bench for onehot_sequencer (SEL_W=4, LAST=5) with an expected-value queue per step.
module tb_onehot_sequencer;
   logic clk;
   logic clr_n;
   int   checks;
   int   failures;

   typedef struct packed {
      logic [3:0]  sel;
      logic [15:0] out;
      logic        wrap;
      logic        halted;
   } exp_t;

   exp_t        q[$];
   logic [15:0] prev_out;
   logic        prev_wrap;

   onehot_sequencer_if #(.SEL_W(4)) bus ();

   onehot_sequencer #(.SEL_W(4), .LAST(5)) dut (
      .clk   (clk),
      .clr_n (clr_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, ".sel"},    32'(bus.sel_q),  32'h0);
      check({tag, ".out"},    32'(bus.out),    32'h0);
      check({tag, ".wrap"},   32'(bus.wrap),   32'h0);
      check({tag, ".halted"}, 32'(bus.halted), 32'h0);
   endtask

   // Drive one cycle of requests, queue the state expected after the edge, then compare.
   task automatic step(input string tag, input logic e, input logic r, input logic l,
                       input logic [3:0] ls, input logic h,
                       input logic [3:0] xs, input logic [15:0] xo,
                       input logic xw, input logic xh);
      exp_t        x;
      exp_t        got;
      logic [15:0] want_out;
      logic        want_wrap;
      bus.en = e; bus.restart = r; bus.load = l; bus.load_sel = ls; bus.hlt = h;
      x.sel = xs; x.out = xo; x.wrap = xw; x.halted = xh;
      q.push_back(x);
      @(posedge clk);
      #1;
      got = q.pop_front();
`ifdef ONEHOT_OUT_REG_EN
      want_out  = prev_out;
      want_wrap = prev_wrap;
      prev_out  = got.out;
      prev_wrap = got.wrap;
`else
      want_out  = got.out;
      want_wrap = got.wrap;
`endif
      $display("step %s: sel=%0d out=%04h wrap=%0b halted=%0b", tag,
               bus.sel_q, bus.out, bus.wrap, bus.halted);
      check({tag, ".sel"},    32'(bus.sel_q),  32'(got.sel));
      check({tag, ".out"},    32'(bus.out),    32'(want_out));
      check({tag, ".wrap"},   32'(bus.wrap),   32'(want_wrap));
      check({tag, ".halted"}, 32'(bus.halted), 32'(got.halted));
   endtask

   initial begin
      checks = 0; failures = 0;
      prev_out = '0; prev_wrap = 1'b0;
      bus.en = 0; bus.restart = 0; bus.load = 0; bus.load_sel = '0; bus.hlt = 0;
      clr_n = 1'b0;
      #2;
      check_zero("reset");
      @(negedge clk);
      clr_n = 1'b1;
      @(posedge clk);
      #1;

      // Free-running count with wrap after index 5
      step("run0", 1, 0, 0, 4'd0, 0, 4'd0, 16'h0001, 0, 0);
      step("run1", 1, 0, 0, 4'd0, 0, 4'd1, 16'h0002, 0, 0);
      step("run2", 1, 0, 0, 4'd0, 0, 4'd2, 16'h0004, 0, 0);
      step("run3", 1, 0, 0, 4'd0, 0, 4'd3, 16'h0008, 0, 0);
      step("run4", 1, 0, 0, 4'd0, 0, 4'd4, 16'h0010, 0, 0);
      step("run5", 1, 0, 0, 4'd0, 0, 4'd5, 16'h0020, 0, 0);
      step("run6", 1, 0, 0, 4'd0, 0, 4'd0, 16'h0001, 1, 0);
      step("run7", 1, 0, 0, 4'd0, 0, 4'd1, 16'h0002, 0, 0);

      // Halt at index 3, en ignored, restart exits
      step("to2",  1, 0, 0, 4'd0, 0, 4'd2, 16'h0004, 0, 0);
      step("to3",  1, 0, 0, 4'd0, 0, 4'd3, 16'h0008, 0, 0);
      step("hlt",  1, 0, 0, 4'd0, 1, 4'd3, 16'h0000, 0, 1);
      for (int i = 0; i < 4; i++)
         step("hold_en", 1, 0, 0, 4'd0, 0, 4'd3, 16'h0000, 0, 1);
      step("hlt_again", 0, 0, 0, 4'd0, 1, 4'd3, 16'h0000, 0, 1);
      step("restart", 0, 1, 0, 4'd0, 0, 4'd0, 16'h0001, 0, 0);

      // Load with clamp and in-range target
      step("to1",  1, 0, 0, 4'd0, 0, 4'd1, 16'h0002, 0, 0);
      step("to2b", 1, 0, 0, 4'd0, 0, 4'd2, 16'h0004, 0, 0);
      step("load9", 0, 0, 1, 4'd9, 0, 4'd0, 16'h0001, 0, 0);
      step("load4", 1, 0, 1, 4'd4, 0, 4'd4, 16'h0010, 0, 0);
      step("idle_hold", 0, 0, 0, 4'd0, 0, 4'd4, 16'h0010, 0, 0);

      // Priority: restart beats load and hlt
      step("prio", 1, 1, 1, 4'd3, 1, 4'd0, 16'h0001, 0, 0);
      // Load beats hlt; load from HALT; load to LAST then wrap
      step("load_hlt", 0, 0, 1, 4'd4, 1, 4'd4, 16'h0010, 0, 0);
      step("hlt4", 0, 0, 0, 4'd0, 1, 4'd4, 16'h0000, 0, 1);
      step("load_halt", 0, 0, 1, 4'd5, 0, 4'd5, 16'h0020, 0, 0);
      step("wrap2", 1, 0, 0, 4'd0, 0, 4'd0, 16'h0001, 1, 0);
      step("load5", 0, 0, 1, 4'd5, 0, 4'd5, 16'h0020, 0, 0);
      step("restart_last", 1, 1, 0, 4'd0, 0, 4'd0, 16'h0001, 0, 0);

      // Asynchronous reset in the middle of HALT
      step("to1c", 1, 0, 0, 4'd0, 0, 4'd1, 16'h0002, 0, 0);
      step("hlt1", 0, 0, 0, 4'd0, 1, 4'd1, 16'h0000, 0, 1);
      #3;
      clr_n = 1'b0;
      #1;
      check_zero("async_rst");
      #1;
      clr_n = 1'b1;
      prev_out = '0; prev_wrap = 1'b0;
      step("idle", 0, 0, 0, 4'd0, 0, 4'd0, 16'h0000, 0, 0);
      step("idle_hlt", 0, 0, 0, 4'd0, 1, 4'd0, 16'h0000, 0, 0);
      step("first_en", 1, 0, 0, 4'd0, 0, 4'd0, 16'h0001, 0, 0);
      step("next_en", 1, 0, 0, 4'd0, 0, 4'd1, 16'h0002, 0, 0);
      // Load directly from IDLE after another reset
      clr_n = 1'b0;
      #1;
      clr_n = 1'b1;
      prev_out = '0; prev_wrap = 1'b0;
      step("idle_load", 0, 0, 1, 4'd3, 0, 4'd3, 16'h0008, 0, 0);
      step("tail", 0, 0, 0, 4'd0, 0, 4'd3, 16'h0008, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
